// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings, writeback FSM states and data-bus payload types.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } wb_state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP,
        CLS_ALU
    } wb_class_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } dbus_cmd_t;

    // Encodings without the 2'b11 low bits are treated as "no instruction present".
    function automatic wb_class_e classify(input logic [6:0] opcode);
        wb_class_e cls;
        cls = CLS_NONE;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                OPC_LOAD:                         cls = CLS_LOAD;
                OPC_STORE:                        cls = CLS_STORE;
                OPC_JAL, OPC_JALR:                cls = CLS_JUMP;
                OPC_LUI, OPC_AUIPC,
                OPC_OP_IMM, OPC_OP:               cls = CLS_ALU;
                default:                          cls = CLS_NONE;
            endcase
        end
        return cls;
    endfunction

    // size is func3[1:0]; the unused 2'b11 size is always rejected.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~addr_lo[0];
            2'b10:   ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Data-memory request/acknowledge bus between the writeback stage and memory.
interface writeback_stage_if;
    import riscv_pkg::*;

    logic              dbus_req;
    logic              dbus_we;
    logic [XLEN-1:0]   dbus_addr;
    logic [XLEN-1:0]   dbus_wdata;
    logic [STRB_W-1:0] dbus_wstrb;
    logic              dbus_ack;
    logic [XLEN-1:0]   dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ack, dbus_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]        func3,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_word,
    output logic [XLEN-1:0]   store_wdata_c,
    output logic [STRB_W-1:0] store_wstrb_c,
    output logic [XLEN-1:0]   load_data_c
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Narrow stores replicate their data across every lane; strobes pick the real one.
    always_comb begin : store_lanes
        store_wdata_c = store_data;
        store_wstrb_c = '1;
        case (func3[1:0])
            2'b00: begin
                store_wdata_c = {4{store_data[7:0]}};
                store_wstrb_c = STRB_W'(4'b0001 << addr_lo);
            end
            2'b01: begin
                store_wdata_c = {2{store_data[15:0]}};
                store_wstrb_c = STRB_W'(4'b0011 << {addr_lo[1], 1'b0});
            end
            default: ;
        endcase
    end

    always_comb begin : load_lanes
        load_byte   = load_word[{addr_lo, 3'b000} +: 8];
        load_half   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        load_data_c = load_word;
        case (func3)
            F3_B:    load_data_c = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_data_c = {{16{load_half[15]}}, load_half};
            F3_BU:   load_data_c = {24'd0, load_byte};
            F3_HU:   load_data_c = {16'd0, load_half};
            default: load_data_c = load_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: data-memory access FSM with timeout, load capture and register write-back mux.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instruction_ppl,
    input  logic [XLEN-1:0] PC_ppl,
    input  logic [XLEN-1:0] ALU_ppl,
    input  logic [XLEN-1:0] rdata2_forwarded_ppl,
    writeback_stage_if.master dbus,
    output logic [XLEN-1:0] wdata,
    output logic            reg_wr,
    output logic            stall,
    output logic            misaligned,
    output logic            bus_err
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_e          state_q, state_d;
    wb_class_e          cls;
    logic [2:0]         func3;
    logic [4:0]         rd;
    logic               mem_op;
    logic               aligned;
    logic               start, capture, abort;

    logic               req_q;
    dbus_cmd_t          cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    load_q;
    logic               err_q;

    logic [XLEN-1:0]    st_wdata_c;
    logic [STRB_W-1:0]  st_wstrb_c;
    logic [XLEN-1:0]    ld_data_c;
    logic               unused_instr_bits;

    assign cls     = classify(instruction_ppl[6:0]);
    assign func3   = instruction_ppl[14:12];
    assign rd      = instruction_ppl[11:7];
    assign mem_op  = (cls == CLS_LOAD) || (cls == CLS_STORE);
    assign aligned = is_aligned(func3[1:0], ALU_ppl[1:0]);
    assign unused_instr_bits = ^instruction_ppl[31:15];

    lsu_align u_lsu_align (
        .func3         (func3),
        .addr_lo       (ALU_ppl[1:0]),
        .store_data    (rdata2_forwarded_ppl),
        .load_word     (load_q),
        .store_wdata_c (st_wdata_c),
        .store_wstrb_c (st_wstrb_c),
        .load_data_c   (ld_data_c)
    );

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational stall / misaligned strobes.
    always_comb begin : fsm_next
        state_d    = state_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        start      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        stall   = 1'b1;
                        start   = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dbus.dbus_ack) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request payload is frozen at issue so the bus sees stable values until ack.
    always_comb begin : cmd_build
        cmd_d       = '0;
        cmd_d.addr  = {ALU_ppl[XLEN-1:2], 2'b00};
        if (cls == CLS_STORE) begin
            cmd_d.we    = 1'b1;
            cmd_d.wdata = st_wdata_c;
            cmd_d.wstrb = st_wstrb_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : bus_regs
        if (!rst) begin
            req_q  <= 1'b0;
            cmd_q  <= '0;
            cnt_q  <= '0;
            load_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= abort;
            if (start) begin
                req_q <= 1'b1;
                cmd_q <= cmd_d;
                cnt_q <= '0;
            end else if (capture || abort) begin
                req_q <= 1'b0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                load_q <= dbus.dbus_rdata;
            end
        end
    end

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = cmd_q.we;
    assign dbus.dbus_addr  = cmd_q.addr;
    assign dbus.dbus_wdata = cmd_q.wdata;
    assign dbus.dbus_wstrb = cmd_q.wstrb;
    assign bus_err         = err_q;

    // Loads write only in DONE after a real ack; rd == x0 never writes.
    always_comb begin : wb_mux
        wdata  = '0;
        reg_wr = 1'b0;
        case (cls)
            CLS_LOAD: begin
                if (state_q == DONE) begin
                    wdata  = ld_data_c;
                    reg_wr = (rd != 5'd0) && !err_q;
                end
            end
            CLS_JUMP: begin
                wdata  = PC_ppl + XLEN'(4);
                reg_wr = (rd != 5'd0) && !stall;
            end
            CLS_ALU: begin
                wdata  = ALU_ppl;
                reg_wr = (rd != 5'd0) && !stall;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with queued expected load results and store commands.
module tb_writeback_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_ppl;
    logic [31:0] PC_ppl;
    logic [31:0] ALU_ppl;
    logic [31:0] rdata2_forwarded_ppl;
    logic [31:0] wdata;
    logic        reg_wr;
    logic        stall;
    logic        misaligned;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] load_exp_q [$];
    dbus_cmd_t   store_exp_q [$];

    writeback_stage_if bus ();

    writeback_stage #(.TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_ppl      (instruction_ppl),
        .PC_ppl               (PC_ppl),
        .ALU_ppl              (ALU_ppl),
        .rdata2_forwarded_ppl (rdata2_forwarded_ppl),
        .dbus                 (bus),
        .wdata                (wdata),
        .reg_wr               (reg_wr),
        .stall                (stall),
        .misaligned           (misaligned),
        .bus_err              (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, opc, 2'b11};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] want;
        @(negedge clk);
        instruction_ppl  = mk(OPC_LOAD, f3, rd);
        ALU_ppl          = addr;
        bus.dbus_ack     = 1'b0;
        bus.dbus_rdata   = rdata;
        load_exp_q.push_back(exp);
        #1;
        check("ld_idle_stall", 32'(stall), 32'd1);
        check("ld_idle_req", 32'(bus.dbus_req), 32'd0);
        check("ld_idle_wr", 32'(reg_wr), 32'd0);
        @(negedge clk);
        check("ld_acc_req", 32'(bus.dbus_req), 32'd1);
        check("ld_acc_stall", 32'(stall), 32'd1);
        check("ld_acc_we", 32'(bus.dbus_we), 32'd0);
        check("ld_acc_addr", bus.dbus_addr, addr & 32'hFFFF_FFFC);
        bus.dbus_ack = 1'b1;
        @(negedge clk);
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = 32'h0;
        #1;
        check("ld_done_stall", 32'(stall), 32'd0);
        check("ld_done_req", 32'(bus.dbus_req), 32'd0);
        check("ld_done_wr", 32'(reg_wr), 32'(rd != 5'd0));
        want = load_exp_q.pop_front();
        check("ld_done_data", wdata, want);
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [31:0] lanes);
        dbus_cmd_t want;
        @(negedge clk);
        instruction_ppl      = mk(OPC_STORE, f3, 5'd3);
        ALU_ppl              = addr;
        rdata2_forwarded_ppl = data;
        bus.dbus_ack         = 1'b0;
        store_exp_q.push_back('{we: 1'b1, addr: addr & 32'hFFFF_FFFC, wdata: lanes, wstrb: strb});
        #1;
        check("st_idle_stall", 32'(stall), 32'd1);
        check("st_idle_wr", 32'(reg_wr), 32'd0);
        @(negedge clk);
        want = store_exp_q.pop_front();
        for (int c = 0; c < 2; c++) begin
            check("st_acc_req", 32'(bus.dbus_req), 32'd1);
            check("st_acc_we", 32'(bus.dbus_we), 32'(want.we));
            check("st_acc_addr", bus.dbus_addr, want.addr);
            check("st_acc_wdata", bus.dbus_wdata, want.wdata);
            check("st_acc_wstrb", 32'(bus.dbus_wstrb), 32'(want.wstrb));
            check("st_acc_wr", 32'(reg_wr), 32'd0);
            if (c == 1) bus.dbus_ack = 1'b1;
            @(negedge clk);
        end
        bus.dbus_ack = 1'b0;
        #1;
        check("st_done_req", 32'(bus.dbus_req), 32'd0);
        check("st_done_stall", 32'(stall), 32'd0);
        check("st_done_wr", 32'(reg_wr), 32'd0);
    endtask

    initial begin
        rst                  = 1'b0;
        instruction_ppl      = 32'h0;
        PC_ppl               = 32'h0;
        ALU_ppl              = 32'h0;
        rdata2_forwarded_ppl = 32'h0;
        bus.dbus_ack         = 1'b0;
        bus.dbus_rdata       = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.dbus_req), 32'd0);
        check("rst_we", 32'(bus.dbus_we), 32'd0);
        check("rst_addr", bus.dbus_addr, 32'd0);
        check("rst_bwdata", bus.dbus_wdata, 32'd0);
        check("rst_wstrb", 32'(bus.dbus_wstrb), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wr", 32'(reg_wr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_misal", 32'(misaligned), 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_req", 32'(bus.dbus_req), 32'd0);
        check("post_rst_wr", 32'(reg_wr), 32'd0);

        // Loads: word, signed/unsigned byte and half
        run_load(F3_W,  5'd5, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_load(F3_B,  5'd6, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load(F3_BU, 5'd6, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080);
        run_load(F3_H,  5'd8, 32'h0000_0102, 32'h8001_1234, 32'hFFFF_8001);
        run_load(F3_HU, 5'd8, 32'h0000_0100, 32'h8001_F234, 32'h0000_F234);
        run_load(F3_W,  5'd0, 32'h0000_0104, 32'h1111_2222, 32'h1111_2222);

        // Stores: half, byte, word lanes
        run_store(F3_H, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        run_store(F3_B, 32'h0000_0201, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        run_store(F3_W, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Misaligned word and half
        @(negedge clk);
        instruction_ppl = mk(OPC_LOAD, F3_W, 5'd5);
        ALU_ppl         = 32'h0000_0101;
        #1;
        check("mis_w_pulse", 32'(misaligned), 32'd1);
        check("mis_w_stall", 32'(stall), 32'd0);
        check("mis_w_wr", 32'(reg_wr), 32'd0);
        @(negedge clk);
        instruction_ppl = mk(OPC_LOAD, F3_H, 5'd5);
        ALU_ppl         = 32'h0000_0103;
        #1;
        check("mis_w_noreq", 32'(bus.dbus_req), 32'd0);
        check("mis_h_pulse", 32'(misaligned), 32'd1);
        @(negedge clk);
        instruction_ppl = 32'h0;
        #1;
        check("mis_clear", 32'(misaligned), 32'd0);
        check("mis_h_noreq", 32'(bus.dbus_req), 32'd0);

        // Ack withheld: TIMEOUT=4 ACCESS cycles then a bus_err pulse
        @(negedge clk);
        instruction_ppl = mk(OPC_LOAD, F3_W, 5'd4);
        ALU_ppl         = 32'h0000_0040;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("to_acc_req", 32'(bus.dbus_req), 32'd1);
            check("to_acc_stall", 32'(stall), 32'd1);
            check("to_acc_err", 32'(bus_err), 32'd0);
            @(negedge clk);
        end
        check("to_done_err", 32'(bus_err), 32'd1);
        check("to_done_wr", 32'(reg_wr), 32'd0);
        check("to_done_req", 32'(bus.dbus_req), 32'd0);
        check("to_done_stall", 32'(stall), 32'd0);
        @(negedge clk);
        instruction_ppl = 32'h0;
        #1;
        check("to_err_clear", 32'(bus_err), 32'd0);
        check("to_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Jump wrap and ALU results
        @(negedge clk);
        instruction_ppl = mk(OPC_JAL, 3'd0, 5'd1);
        PC_ppl          = 32'hFFFF_FFFC;
        #1;
        check("jal_wdata", wdata, 32'h0000_0000);
        check("jal_wr", 32'(reg_wr), 32'd1);
        check("jal_stall", 32'(stall), 32'd0);
        @(negedge clk);
        instruction_ppl = mk(OPC_OP, 3'd0, 5'd7);
        ALU_ppl         = 32'h0000_0055;
        #1;
        check("alu_wdata", wdata, 32'h0000_0055);
        check("alu_wr", 32'(reg_wr), 32'd1);
        @(negedge clk);
        instruction_ppl = mk(OPC_LUI, 3'd0, 5'd0);
        #1;
        check("alu_x0_wr", 32'(reg_wr), 32'd0);

        // Reset in the middle of ACCESS
        @(negedge clk);
        instruction_ppl = mk(OPC_LOAD, F3_W, 5'd9);
        ALU_ppl         = 32'h0000_0300;
        @(negedge clk);
        check("rma_req_before", 32'(bus.dbus_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rma_req", 32'(bus.dbus_req), 32'd0);
        check("rma_state", 32'(dut.state_q), 32'(IDLE));
        check("rma_err", 32'(bus_err), 32'd0);
        check("rma_wr", 32'(reg_wr), 32'd0);
        instruction_ppl = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rma_after_err", 32'(bus_err), 32'd0);
        check("rma_after_wr", 32'(reg_wr), 32'd0);
        check("rma_after_req", 32'(bus.dbus_req), 32'd0);
        run_load(F3_W, 5'd9, 32'h0000_0300, 32'h0BAD_F00D, 32'h0BAD_F00D);

        @(negedge clk);
        instruction_ppl = 32'h0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles without dbus_ack before abort.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port instruction_ppl  input  32: instruction held in the Decode/Writeback pipeline register.
REQ-005 SHALL have port PC_ppl  input  32: PC of that instruction.
REQ-006 SHALL have port ALU_ppl  input  32: ALU result, used as the effective address for load and store.
REQ-007 SHALL have port rdata2_forwarded_ppl  input  32: store data.
REQ-008 SHALL have ports dbus_req (output 1), dbus_we (output 1), dbus_addr (output 32, word-aligned), dbus_wdata (output 32), dbus_wstrb (output 4), dbus_ack (input 1), dbus_rdata (input 32): data-memory request/acknowledge bus.
REQ-009 SHALL have ports wdata (output 32) and reg_wr (output 1): register-file write-back, with the destination address taken from instruction_ppl[11:7].
REQ-010 SHALL have port stall  output  1: freezes upstream pipeline registers.
REQ-011 SHALL have ports misaligned (output 1) and bus_err (output 1): one-cycle fault pulses.

Function
REQ-012 SHALL classify instruction_ppl[6:2]: 00000 load, 01000 store, 11011/11001 jump, 01101/00101/00100/01100 ALU-result, all others no-write.
REQ-013 SHALL implement FSM IDLE, ACCESS, DONE; reset state is IDLE.
REQ-014 In IDLE with an aligned load or store present, SHALL assert stall combinationally and go to ACCESS on the next edge.
REQ-015 In ACCESS, dbus_req SHALL be driven from a register, and dbus_addr/we/wdata/wstrb SHALL stay stable until dbus_ack is sampled high.
REQ-016 On dbus_ack in ACCESS, SHALL capture dbus_rdata into load_q, deassert dbus_req, and go to DONE.
REQ-017 If TIMEOUT ACCESS cycles elapse without ack (8-bit counter, cleared on entering ACCESS), SHALL go to DONE with bus_err pulsed and reg_wr suppressed in DONE.
REQ-018 In DONE, stall SHALL be 0, and the FSM SHALL return to IDLE unconditionally on the next edge; a following memory op then restarts from IDLE.
REQ-019 stall SHALL be 1 in IDLE when a memory op is present and throughout ACCESS, and 0 otherwise.
REQ-020 Minimum load latency SHALL be IDLE(stall) -> ACCESS(ack) -> DONE(write), giving 2 stall cycles.
REQ-021 Alignment SHALL be: func3[1:0]=00 any address, 01 requires addr[0]=0, 10 requires addr[1:0]=00.
REQ-022 A misaligned access SHALL pulse misaligned in IDLE, issue no bus request, assert no stall, and assert no reg_wr.
REQ-023 Store lanes SHALL be: SB wstrb=0001<<addr[1:0] with the byte replicated ×4; SH wstrb=0011<<{addr[1],1'b0} with the half replicated ×2; SW wstrb=1111.
REQ-024 Load extraction SHALL select the byte or half of load_q by addr, sign-extend for LB/LH (func3 000/001), and zero-extend for LBU/LHU (100/101).
REQ-025 wdata SHALL be: load -> extracted load_q (in DONE); jump -> PC_ppl+4 (mod 2^32); ALU-result -> ALU_ppl.
REQ-026 reg_wr SHALL be 1 only for write classes, only when not stalled, and only when rd != 0; for loads, only in DONE without bus_err.
REQ-027 Stores SHALL never assert reg_wr.

Reset
REQ-028 On rst low, SHALL asynchronously force FSM=IDLE, dbus_req=0, load_q=0, and timeout counter=0.
REQ-029 A reset in ACCESS SHALL abandon the transaction, with no write-back and no fault pulse.
REQ-030 After reset, all outputs SHALL be 0 until the first instruction is present.

Structure
REQ-031 Opcode and func3 encodings and the FSM state enum SHALL live in the shared package riscv_pkg, which Decode also imports.
REQ-032 Lane steering and extension SHALL be the combinational sub-module lsu_align; the FSM, counter, load_q, and write-back mux SHALL stay in writeback_stage.

Verification
REQ-033 LW at addr 0x100 with dbus_rdata=0xDEADBEEF and ack in the first ACCESS cycle -> stall for 2 cycles, then wdata=0xDEADBEEF with reg_wr=1.
REQ-034 LB at addr 0x103 with rdata=0x80FFFFFF -> wdata=0xFFFFFF80; LBU at the same address -> wdata=0x00000080.
REQ-035 SH at addr 0x202 with data 0x1234ABCD -> dbus_wstrb=1100, dbus_wdata=0xABCDABCD, dbus_we=1, and reg_wr never asserted.
REQ-036 LW at addr 0x101 -> misaligned pulse, dbus_req stays 0, stall=0, reg_wr=0.
REQ-037 Load with ack withheld and TIMEOUT=4 -> 4 ACCESS cycles, then bus_err=1 for 1 cycle, reg_wr=0, and the FSM returns to IDLE.
REQ-038 JAL at PC=0xFFFFFFFC with rd=1 -> wdata=0x00000000 (wrap), reg_wr=1; rst low mid-ACCESS -> dbus_req=0 immediately and the FSM is in IDLE.
